// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//   Memory-access stage of the 16-bit RISC pipeline, sitting directly after
//   the execution stage. Non-memory instructions pass straight through to a
//   registered write-back bundle with one cycle of latency. Loads and stores
//   are issued to data memory over a req/ack handshake. The stage stalls
//   upstream (ex_ready=0) while an access is outstanding.
//
//   Optional feature (macro MEM_TIMEOUT_EN): a watchdog aborts an access that
//   has waited TIMEOUT_CYCLES cycles without ack. It then raises a one-cycle
//   mem_fault together with a null write-back (wb_regwrite=0, wb_data=0).
//   Without the macro, mem_fault is tied to 0.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ex_valid / ex_ready         handshake with the execution stage
//   AluOut, MemoryAddress,      instruction payload from the execution stage
//   StoreData, Mr, Mw,
//   RegWrite, WbReg
//   dmem_req/we/addr/wdata      request to data memory, held until ack
//   dmem_rdata, dmem_ack        response from data memory
//   wb_valid/data/reg/regwrite  write-back bundle, wb_valid is a 1-cycle pulse
//   mem_fault                   1-cycle access-timeout pulse
// ---------------------------------------------------------------------------
module memory_stage #(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [DATA_W-1:0] AluOut,
   input  logic [ADDR_W-1:0] MemoryAddress,
   input  logic [DATA_W-1:0] StoreData,
   input  logic              Mr,
   input  logic              Mw,
   input  logic              RegWrite,
   input  logic [2:0]        WbReg,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [2:0]        wb_reg,
   output logic              wb_regwrite,
   output logic              mem_fault
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t              state_q, state_d;
   logic                req_q, req_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   // Payload of the outstanding memory instruction, replayed on completion.
   logic [DATA_W-1:0]   alu_q, alu_d;
   logic [2:0]          reg_q, reg_d;
   logic                rw_q, rw_d;
   // Write-back bundle.
   logic                wbv_q, wbv_d;
   logic [DATA_W-1:0]   wbd_q, wbd_d;
   logic [2:0]          wbr_q, wbr_d;
   logic                wbrw_q, wbrw_d;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                fault_q, fault_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         alu_q   <= '0;
         reg_q   <= '0;
         rw_q    <= 1'b0;
         wbv_q   <= 1'b0;
         wbd_q   <= '0;
         wbr_q   <= '0;
         wbrw_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         cnt_q   <= '0;
         fault_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         alu_q   <= alu_d;
         reg_q   <= reg_d;
         rw_q    <= rw_d;
         wbv_q   <= wbv_d;
         wbd_q   <= wbd_d;
         wbr_q   <= wbr_d;
         wbrw_q  <= wbrw_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      alu_d   = alu_q;
      reg_d   = reg_q;
      rw_d    = rw_q;
      wbv_d   = 1'b0;            // pulse: only asserted on a completing cycle
      wbd_d   = wbd_q;
      wbr_d   = wbr_q;
      wbrw_d  = wbrw_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d   = cnt_q;
      fault_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (ex_valid) begin
               if (Mw || Mr) begin
                  // Mw wins when both are set: the access is a store.
                  req_d   = 1'b1;
                  we_d    = Mw;
                  addr_d  = MemoryAddress;
                  wdata_d = StoreData;
                  alu_d   = AluOut;
                  reg_d   = WbReg;
                  rw_d    = RegWrite;
                  state_d = S_WAIT;
`ifdef MEM_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end else begin
                  wbv_d  = 1'b1;
                  wbd_d  = AluOut;
                  wbr_d  = WbReg;
                  wbrw_d = RegWrite;
               end
            end
         end
         S_WAIT: begin
            if (dmem_ack) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               wbv_d   = 1'b1;
               wbd_d   = we_q ? alu_q : dmem_rdata;
               wbr_d   = reg_q;
               wbrw_d  = we_q ? 1'b0 : rw_q;
               state_d = S_IDLE;
            end
`ifdef MEM_TIMEOUT_EN
            // Ack is checked first, so it wins over a simultaneous timeout.
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               req_d   = 1'b0;
               we_d    = 1'b0;
               wbv_d   = 1'b1;
               wbd_d   = '0;
               wbr_d   = reg_q;
               wbrw_d  = 1'b0;
               fault_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ex_ready    = (state_q == S_IDLE);
   assign dmem_req    = req_q;
   assign dmem_we     = we_q;
   assign dmem_addr   = addr_q;
   assign dmem_wdata  = wdata_q;
   assign wb_valid    = wbv_q;
   assign wb_data     = wbd_q;
   assign wb_reg      = wbr_q;
   assign wb_regwrite = wbrw_q;
`ifdef MEM_TIMEOUT_EN
   assign mem_fault   = fault_q;
`else
   assign mem_fault   = 1'b0;
`endif

endmodule
